// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard for RAW hazard detection.
// Two combinational read ports, one write port, optional hardwired zero and write bypass.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] writeRegId,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueRegId,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic                  readBusy1,
    output logic                  readBusy2,
    output logic [ADDR_WIDTH:0]   busyCount
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  writeEn;
    logic                  issueEn;
    logic                  countInc;
    logic                  countDec;

    // A write clearing a bit only counts down when no new producer claims the same register.
    always_comb begin
        writeEn  = regWrite && !(ZERO_REG != 0 && writeRegId == '0);
        issueEn  = issueValid && !(ZERO_REG != 0 && issueRegId == '0);
        countInc = issueEn && !busy[issueRegId];
        countDec = writeEn && busy[writeRegId] && !(issueEn && issueRegId == writeRegId);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            busyCount <= '0;
        end else begin
            if (writeEn) begin
                regs[writeRegId] <= writeData;
                busy[writeRegId] <= 1'b0;
            end
            // Issue comes last so a same-register issue leaves the bit set.
            if (issueEn) begin
                busy[issueRegId] <= 1'b1;
            end
            if (countInc && !countDec) begin
                busyCount <= busyCount + (ADDR_WIDTH+1)'(1);
            end else if (countDec && !countInc) begin
                busyCount <= busyCount - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    always_comb begin
        readData1 = regs[readReg1];
        readBusy1 = busy[readReg1];
        if (ZERO_REG != 0 && readReg1 == '0) begin
            readData1 = '0;
            readBusy1 = 1'b0;
        end else if (BYPASS != 0 && regWrite && writeRegId == readReg1) begin
            readData1 = writeData;
            readBusy1 = 1'b0;
        end
    end

    always_comb begin
        readData2 = regs[readReg2];
        readBusy2 = busy[readReg2];
        if (ZERO_REG != 0 && readReg2 == '0) begin
            readData2 = '0;
            readBusy2 = 1'b0;
        end else if (BYPASS != 0 && regWrite && writeRegId == readReg2) begin
            readData2 = writeData;
            readBusy2 = 1'b0;
        end
    end
endmodule
